param_fir: RTL and testbench

Parametrised, valid-qualified, transposed-form FIR filter; next generation of the team's fixed pipelined FIR.
- Adds generic tap count and widths, runtime-loadable double-buffered coefficients, sample-gated operation, rounding/saturating output with an overflow flag, and a synchronous flush.
- Sits in the DSP datapath between the sample source (ADC/stimulus) and downstream decimation or capture logic.

---
 rtl/fir_pkg.sv | 42 ++++
 rtl/fir_coef_bank.sv | 43 ++++
 rtl/param_fir.sv | 120 ++++++++++++
 tb/tb_param_fir.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared arithmetic helpers for the parametrised FIR datapath.
// Latency: combinational helpers only.
// Backpressure: none; pure functions.
package fir_pkg;

    localparam int WIDE_W = 128;
    typedef logic signed [WIDE_W-1:0] wide_t;

    function automatic int acc_width(input int din_w, input int coef_w, input int ntaps);
        return din_w + coef_w + $clog2(ntaps);
    endfunction

    // Round half up, then arithmetic shift; shift of 0 passes the value through.
    function automatic wide_t round_shift(input wide_t v, input int shift);
        wide_t res;
        res = v;
        if (shift > 0) begin
            res = (v + (wide_t'(1) <<< (shift - 1))) >>> shift;
        end
        return res;
    endfunction

    // Clamp to the signed range of out_w bits; ovf reports whether clamping happened.
    function automatic wide_t saturate(input wide_t v, input int out_w, output logic ovf);
        wide_t hi;
        wide_t lo;
        wide_t res;
        hi  = (wide_t'(1) <<< (out_w - 1)) - wide_t'(1);
        lo  = -(wide_t'(1) <<< (out_w - 1));
        res = v;
        ovf = 1'b0;
        if (v > hi) begin
            res = hi;
            ovf = 1'b1;
        end else if (v < lo) begin
            res = lo;
            ovf = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Double-buffered coefficient store: shadow bank written per tap, copied wholesale to active.
// Latency: write and swap take effect on the edge they are presented.
// Backpressure: none; every write/swap is accepted.
module fir_coef_bank #(
    parameter int NTAPS  = 8,
    parameter int COEF_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       coef_we,
    input  logic [$clog2(NTAPS)-1:0]   coef_addr,
    input  logic [COEF_W-1:0]          coef_wdata,
    input  logic                       coef_swap,
    output logic [NTAPS*COEF_W-1:0]    coef_act
);

    logic [COEF_W-1:0] shadow [NTAPS];
    logic [COEF_W-1:0] active [NTAPS];

    // Swap reads the shadow value from before any same-edge write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NTAPS; k++) begin
                shadow[k] <= '0;
                active[k] <= '0;
            end
        end else begin
            if (coef_swap) begin
                for (int k = 0; k < NTAPS; k++) begin
                    active[k] <= shadow[k];
                end
            end
            if (coef_we && (int'(coef_addr) < NTAPS)) begin
                shadow[coef_addr] <= coef_wdata;
            end
        end
    end

    for (genvar k = 0; k < NTAPS; k++) begin : g_flat
        assign coef_act[k*COEF_W +: COEF_W] = active[k];
    end

endmodule

// File: rtl/param_fir.sv
// Transposed-form FIR with runtime-swappable coefficients, rounding and saturation.
// Latency: 3 cycles from accepted sample to dout_valid; one sample per cycle.
// Backpressure: none; idle cycles freeze the partial sums, clear flushes them.
module param_fir
    import fir_pkg::*;
#(
    parameter int NTAPS  = 8,
    parameter int DIN_W  = 16,
    parameter int COEF_W = 16,
    parameter int DOUT_W = 32,
    parameter int SHIFT  = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic signed [DIN_W-1:0]   din,
    input  logic                      din_valid,
    input  logic                      clear,
    input  logic                      coef_we,
    input  logic [$clog2(NTAPS)-1:0]  coef_addr,
    input  logic signed [COEF_W-1:0]  coef_wdata,
    input  logic                      coef_swap,
    output logic signed [DOUT_W-1:0]  dout,
    output logic                      dout_valid,
    output logic                      ovf
);

    localparam int PROD_W = DIN_W + COEF_W;
    localparam int ACC_W  = acc_width(DIN_W, COEF_W, NTAPS);

    logic [NTAPS*COEF_W-1:0]   coef_flat;
    logic signed [COEF_W-1:0]  coef_act [NTAPS];
    logic signed [PROD_W-1:0]  prod     [NTAPS];
    logic signed [ACC_W-1:0]   z        [NTAPS];
    logic                      va;
    logic                      vb;
    logic signed [DOUT_W-1:0]  dout_nxt;
    logic                      ovf_nxt;

    fir_coef_bank #(
        .NTAPS  (NTAPS),
        .COEF_W (COEF_W)
    ) u_coef_bank (
        .clk        (clk),
        .rst        (rst),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .coef_swap  (coef_swap),
        .coef_act   (coef_flat)
    );

    for (genvar k = 0; k < NTAPS; k++) begin : g_unpack
        assign coef_act[k] = $signed(coef_flat[k*COEF_W +: COEF_W]);
    end

    // Stage A: broadcast the sample against every active tap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            va <= 1'b0;
            for (int k = 0; k < NTAPS; k++) begin
                prod[k] <= '0;
            end
        end else if (clear) begin
            va <= 1'b0;
        end else begin
            va <= din_valid;
            if (din_valid) begin
                for (int k = 0; k < NTAPS; k++) begin
                    prod[k] <= PROD_W'(din) * PROD_W'(coef_act[k]);
                end
            end
        end
    end

    // Stage B: partial sums advance only on real samples, so gaps do not disturb history.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vb <= 1'b0;
            for (int k = 0; k < NTAPS; k++) begin
                z[k] <= '0;
            end
        end else if (clear) begin
            vb <= 1'b0;
            for (int k = 0; k < NTAPS; k++) begin
                z[k] <= '0;
            end
        end else begin
            vb <= va;
            if (va) begin
                for (int k = 0; k < NTAPS-1; k++) begin
                    z[k] <= ACC_W'(prod[k]) + z[k+1];
                end
                z[NTAPS-1] <= ACC_W'(prod[NTAPS-1]);
            end
        end
    end

    always_comb begin
        ovf_nxt  = 1'b0;
        dout_nxt = DOUT_W'(saturate(round_shift(wide_t'(z[0]), SHIFT), DOUT_W, ovf_nxt));
    end

    // Stage C: dout and ovf hold between samples; only the valid strobe drops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            ovf        <= 1'b0;
        end else if (clear) begin
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= vb;
            if (vb) begin
                dout <= dout_nxt;
                ovf  <= ovf_nxt;
            end
        end
    end

endmodule

// File: tb/tb_param_fir.sv
// Directed bench for param_fir: three instances share stimulus (32-bit, 16-bit saturating, SHIFT=2).
module tb_param_fir;

    logic               clk        = 1'b0;
    logic               rst        = 1'b1;
    logic signed [15:0] din        = '0;
    logic               din_valid  = 1'b0;
    logic               clear      = 1'b0;
    logic               coef_we    = 1'b0;
    logic [2:0]         coef_addr  = '0;
    logic signed [15:0] coef_wdata = '0;
    logic               coef_swap  = 1'b0;

    logic signed [31:0] dout;
    logic               dout_valid;
    logic               ovf;
    logic signed [15:0] s16_dout;
    logic               s16_valid;
    logic               s16_ovf;
    logic signed [31:0] r2_dout;
    logic               r2_valid;
    logic               r2_ovf;

    int passed = 0;
    int total  = 0;

    logic               iv_q [$];
    logic               ov_q [$];
    logic signed [31:0] od_q [$];
    logic               oo_q [$];
    logic               sv_q [$];
    logic signed [15:0] sd_q [$];
    logic               so_q [$];
    logic               rv_q [$];
    logic signed [31:0] rd_q [$];

    always #5 clk = ~clk;

    param_fir #(.NTAPS(8), .DIN_W(16), .COEF_W(16), .DOUT_W(32), .SHIFT(0)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clear(clear),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata), .coef_swap(coef_swap),
        .dout(dout), .dout_valid(dout_valid), .ovf(ovf)
    );

    param_fir #(.NTAPS(8), .DIN_W(16), .COEF_W(16), .DOUT_W(16), .SHIFT(0)) dut_s16 (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clear(clear),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata), .coef_swap(coef_swap),
        .dout(s16_dout), .dout_valid(s16_valid), .ovf(s16_ovf)
    );

    param_fir #(.NTAPS(8), .DIN_W(16), .COEF_W(16), .DOUT_W(32), .SHIFT(2)) dut_r2 (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clear(clear),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata), .coef_swap(coef_swap),
        .dout(r2_dout), .dout_valid(r2_valid), .ovf(r2_ovf)
    );

    task automatic flush_q();
        iv_q.delete(); ov_q.delete(); od_q.delete(); oo_q.delete();
        sv_q.delete(); sd_q.delete(); so_q.delete(); rv_q.delete(); rd_q.delete();
    endtask

    // Present one cycle of inputs, step past the edge, record what every instance shows.
    task automatic cyc(input logic v, input int d, input logic we = 1'b0, input int addr = 0,
                       input int wd = 0, input logic sw = 1'b0, input logic clr = 1'b0);
        din_valid  = v;
        din        = 16'(d);
        coef_we    = we;
        coef_addr  = 3'(addr);
        coef_wdata = 16'(wd);
        coef_swap  = sw;
        clear      = clr;
        @(posedge clk);
        #1;
        iv_q.push_back(v);
        ov_q.push_back(dout_valid); od_q.push_back(dout);     oo_q.push_back(ovf);
        sv_q.push_back(s16_valid);  sd_q.push_back(s16_dout); so_q.push_back(s16_ovf);
        rv_q.push_back(r2_valid);   rd_q.push_back(r2_dout);
    endtask

    task automatic do_reset();
        din_valid = 1'b0; clear = 1'b0; coef_we = 1'b0; coef_swap = 1'b0;
        rst = 1'b0;
        #10;
        rst = 1'b1;
    endtask

    task automatic load_coefs(input int c [8]);
        for (int k = 0; k < 8; k++) cyc(1'b0, 0, 1'b1, k, c[k]);
        cyc(1'b0, 0, 1'b0, 0, 0, 1'b1);
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        total++; if (dout !== 32'sd0) $display("FAIL reset_dout: got %0d want 0", dout); else passed++;
        total++; if (dout_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", dout_valid); else passed++;
        total++; if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b want 0", ovf); else passed++;
        total++; if (s16_dout !== 16'sd0) $display("FAIL reset_s16_dout: got %0d want 0", s16_dout); else passed++;
        rst = 1'b1;
    endtask

    task automatic test_impulse(input logic gapped);
        int c [8];
        int exp [$];
        int n;
        c = '{1, 2, 3, 4, 5, 6, 7, 8};
        exp = '{1, 2, 3, 4, 5, 6, 7, 8, 0, 0, 0};
        do_reset();
        load_coefs(c);
        flush_q();
        for (int i = 0; i < 11; i++) begin
            cyc(1'b1, (i == 0) ? 1 : 0);
            if (gapped) begin
                cyc(1'b0, 7);
                cyc(1'b0, 7);
            end
        end
        repeat (3) cyc(1'b0, 0);
        n = 0;
        for (int j = 0; j < ov_q.size(); j++) begin
            logic ev;
            int   want;
            ev = (j >= 2) ? iv_q[j-2] : 1'b0;
            total++;
            if (ov_q[j] !== ev) $display("FAIL impulse_valid g=%0b cyc %0d: got %b want %b", gapped, j, ov_q[j], ev);
            else passed++;
            if (ev && ov_q[j]) begin
                want = (n < exp.size()) ? exp[n] : 0;
                total++;
                if (od_q[j] !== want) $display("FAIL impulse_dout g=%0b #%0d: got %0d want %0d", gapped, n, od_q[j], want);
                else passed++;
                n++;
            end
        end
        total++;
        if (n !== exp.size()) $display("FAIL impulse_count g=%0b: got %0d want %0d", gapped, n, exp.size());
        else passed++;
    endtask

    task automatic test_step();
        int c [8];
        int exp [$];
        int n;
        c = '{1, 1, 1, 1, 1, 1, 1, 1};
        exp = '{100, 200, 300, 400, 500, 600, 700, 800, 800, 800, 800, 800};
        do_reset();
        load_coefs(c);
        flush_q();
        repeat (12) cyc(1'b1, 100);
        repeat (3) cyc(1'b0, 0);
        n = 0;
        for (int j = 0; j < ov_q.size(); j++) begin
            logic ev;
            int   want;
            ev = (j >= 2) ? iv_q[j-2] : 1'b0;
            total++;
            if (ov_q[j] !== ev) $display("FAIL step_valid cyc %0d: got %b want %b", j, ov_q[j], ev);
            else passed++;
            if (ev && ov_q[j]) begin
                want = (n < exp.size()) ? exp[n] : 0;
                total++;
                if (od_q[j] !== want || oo_q[j] !== 1'b0)
                    $display("FAIL step_dout #%0d: got %0d ovf %b want %0d ovf 0", n, od_q[j], oo_q[j], want);
                else passed++;
                n++;
            end
        end
        total++;
        if (n !== exp.size()) $display("FAIL step_count: got %0d want %0d", n, exp.size()); else passed++;
    endtask

    task automatic test_swap();
        int c [8];
        int exp [$];
        int n;
        c = '{1, 1, 1, 1, 1, 1, 1, 1};
        exp = '{10, 20, 30, 40, 50, 60, 70, 80, 80, 80,
                80, 80, 80, 80, 80, 80, 80, 80,
                80,
                90, 100, 110, 120, 130, 140, 150, 160, 160, 160};
        do_reset();
        load_coefs(c);
        flush_q();
        repeat (10) cyc(1'b1, 10);
        for (int k = 0; k < 8; k++) cyc(1'b1, 10, 1'b1, k, 2);
        cyc(1'b1, 10, 1'b0, 0, 0, 1'b1);
        repeat (10) cyc(1'b1, 10);
        repeat (3) cyc(1'b0, 0);
        n = 0;
        for (int j = 0; j < ov_q.size(); j++) begin
            logic ev;
            int   want;
            ev = (j >= 2) ? iv_q[j-2] : 1'b0;
            total++;
            if (ov_q[j] !== ev) $display("FAIL swap_valid cyc %0d: got %b want %b", j, ov_q[j], ev);
            else passed++;
            if (ev && ov_q[j]) begin
                want = (n < exp.size()) ? exp[n] : 0;
                total++;
                if (od_q[j] !== want) $display("FAIL swap_dout #%0d: got %0d want %0d", n, od_q[j], want);
                else passed++;
                n++;
            end
        end
        total++;
        if (n !== exp.size()) $display("FAIL swap_count: got %0d want %0d", n, exp.size()); else passed++;
    endtask

    task automatic test_saturation();
        int c [8];
        int exp [$];
        int mexp [3];
        logic movf [3];
        int n;
        int m;
        c = '{32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767};
        exp = '{32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767,
                32767, 32767, 32767, -32768, -32768, -32768, -32768, -32768};
        mexp = '{1073676289, 2147352578, 2147483647};
        movf = '{1'b0, 1'b0, 1'b1};
        do_reset();
        load_coefs(c);
        flush_q();
        repeat (8) cyc(1'b1, 32767);
        repeat (8) cyc(1'b1, -32768);
        repeat (3) cyc(1'b0, 0);
        n = 0;
        m = 0;
        for (int j = 0; j < sv_q.size(); j++) begin
            logic ev;
            int   want;
            ev = (j >= 2) ? iv_q[j-2] : 1'b0;
            total++;
            if (sv_q[j] !== ev) $display("FAIL sat_valid cyc %0d: got %b want %b", j, sv_q[j], ev);
            else passed++;
            if (ev && sv_q[j]) begin
                want = (n < exp.size()) ? exp[n] : 0;
                total++;
                if (sd_q[j] !== want || so_q[j] !== 1'b1)
                    $display("FAIL sat_s16 #%0d: got %0d ovf %b want %0d ovf 1", n, sd_q[j], so_q[j], want);
                else passed++;
                n++;
            end
            if (ev && ov_q[j] && m < 3) begin
                total++;
                if (od_q[j] !== mexp[m] || oo_q[j] !== movf[m])
                    $display("FAIL sat_w32 #%0d: got %0d ovf %b want %0d ovf %b", m, od_q[j], oo_q[j], mexp[m], movf[m]);
                else passed++;
                m++;
            end
        end
        total++;
        if (n !== exp.size()) $display("FAIL sat_count: got %0d want %0d", n, exp.size()); else passed++;
    endtask

    task automatic test_round();
        int c [8];
        int rexp [$];
        int sexp [$];
        int n;
        c = '{1, 0, 0, 0, 0, 0, 0, 0};
        rexp = '{2, 1, -1, 1, 0, 0};
        sexp = '{6, 5, -6, 2, -2, 1};
        do_reset();
        load_coefs(c);
        flush_q();
        for (int i = 0; i < 6; i++) cyc(1'b1, sexp[i]);
        repeat (3) cyc(1'b0, 0);
        n = 0;
        for (int j = 0; j < rv_q.size(); j++) begin
            logic ev;
            ev = (j >= 2) ? iv_q[j-2] : 1'b0;
            total++;
            if (rv_q[j] !== ev) $display("FAIL round_valid cyc %0d: got %b want %b", j, rv_q[j], ev);
            else passed++;
            if (ev && rv_q[j] && n < 6) begin
                total++;
                if (rd_q[j] !== rexp[n]) $display("FAIL round_r2 #%0d: got %0d want %0d", n, rd_q[j], rexp[n]);
                else passed++;
                total++;
                if (sd_q[j] !== sexp[n] || so_q[j] !== 1'b0)
                    $display("FAIL round_s16 #%0d: got %0d ovf %b want %0d ovf 0", n, sd_q[j], so_q[j], sexp[n]);
                else passed++;
                n++;
            end
        end
        total++;
        if (n !== 6) $display("FAIL round_count: got %0d want 6", n); else passed++;
    endtask

    task automatic test_reset_mid();
        int c [8];
        c = '{1, 1, 1, 1, 1, 1, 1, 1};
        do_reset();
        load_coefs(c);
        flush_q();
        repeat (5) cyc(1'b1, 100);
        total++;
        if (dout_valid !== 1'b1 || dout !== 32'sd300)
            $display("FAIL rstmid_pre: got %0d valid %b want 300 valid 1", dout, dout_valid);
        else passed++;
        din_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        total++; if (dout !== 32'sd0) $display("FAIL rstmid_dout: got %0d want 0", dout); else passed++;
        total++; if (dout_valid !== 1'b0) $display("FAIL rstmid_valid: got %b want 0", dout_valid); else passed++;
        @(posedge clk);
        #1;
        rst = 1'b1;
        flush_q();
        repeat (3) cyc(1'b0, 0);
        repeat (4) cyc(1'b1, 100);
        repeat (3) cyc(1'b0, 0);
        for (int j = 0; j < ov_q.size(); j++) begin
            logic ev;
            ev = (j >= 2) ? iv_q[j-2] : 1'b0;
            total++;
            if (ov_q[j] !== ev) $display("FAIL rstmid_after_valid cyc %0d: got %b want %b", j, ov_q[j], ev);
            else passed++;
            if (ev && ov_q[j]) begin
                total++;
                if (od_q[j] !== 32'sd0) $display("FAIL rstmid_coef_zero cyc %0d: got %0d want 0", j, od_q[j]);
                else passed++;
            end
        end
    endtask

    task automatic test_clear();
        int c [8];
        int exp [$];
        int n;
        c = '{1, 1, 1, 1, 1, 1, 1, 1};
        exp = '{100, 200, 300, 100, 200, 300, 400, 500, 600, 700, 800};
        do_reset();
        load_coefs(c);
        flush_q();
        repeat (5) cyc(1'b1, 100);
        cyc(1'b1, 100, 1'b0, 0, 0, 1'b0, 1'b1);
        repeat (8) cyc(1'b1, 100);
        repeat (3) cyc(1'b0, 0);
        n = 0;
        for (int j = 0; j < ov_q.size(); j++) begin
            logic ev;
            int   want;
            ev = ((j >= 2) && (j <= 4)) || ((j >= 8) && (j <= 15));
            total++;
            if (ov_q[j] !== ev) $display("FAIL clear_valid cyc %0d: got %b want %b", j, ov_q[j], ev);
            else passed++;
            if (ev && ov_q[j]) begin
                want = (n < exp.size()) ? exp[n] : 0;
                total++;
                if (od_q[j] !== want) $display("FAIL clear_dout #%0d: got %0d want %0d", n, od_q[j], want);
                else passed++;
                n++;
            end
        end
        total++;
        if (od_q[5] !== 32'sd300) $display("FAIL clear_hold: got %0d want 300", od_q[5]); else passed++;
        total++;
        if (n !== exp.size()) $display("FAIL clear_count: got %0d want %0d", n, exp.size()); else passed++;
    endtask

    initial begin
        test_reset();
        test_impulse(1'b0);
        test_step();
        test_impulse(1'b1);
        test_swap();
        test_saturation();
        test_round();
        test_reset_mid();
        test_clear();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
